// File: rtl/fifo_sync_pkg.sv
// Shared defaults and the data word type for the synchronous FIFO.
package fifo_sync_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 16;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, registered read.
// The read register doubles as the FIFO output register, so it carries
// the dout reset value.
module fifo_ram #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter int                    ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [DATA_WIDTH-1:0] RST_VALUE  = '0
) (
    input  logic                  fifo_clk,
    input  logic                  fifo_rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write port: store the word on an accepted write.
    always_ff @(posedge fifo_clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port: capture the addressed word on an accepted read, hold otherwise.
    always_ff @(posedge fifo_clk or negedge fifo_rst) begin
        if (!fifo_rst) begin
            rd_data_q <= RST_VALUE;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO, standard (non fall-through) read mode. Pointers carry
// an extra wrap bit so occupancy DEPTH and 0 are told apart without a
// spare entry. Flags and counts are registered from next-state occupancy.
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int                    DATA_WIDTH       = DEFAULT_DATA_WIDTH,
    parameter int                    DEPTH            = DEFAULT_DEPTH,
    parameter int                    COUNT_WIDTH      = $clog2(DEPTH) + 1,
    parameter logic [DATA_WIDTH-1:0] DOUT_RESET_VALUE = '0
) (
    input  logic                   fifo_clk,
    input  logic                   fifo_rst,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [COUNT_WIDTH-1:0] wr_data_count,
    output logic [COUNT_WIDTH-1:0] rd_data_count,
    output logic                   wr_ack,
    output logic                   overflow,
    output logic                   data_valid,
    output logic                   underflow,
    output logic                   wr_rst_busy,
    output logic                   rd_rst_busy
);

    localparam int             AW          = $clog2(DEPTH);
    localparam logic [AW:0]    OCC_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]    OCC_AFULL   = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]    OCC_AEMPTY  = (AW+1)'(1);
    localparam logic [1:0]     BUSY_CYCLES = 2'd3;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] occ_q, occ_d;
    logic [1:0]  busy_cnt_q, busy_cnt_d;
    logic        busy;
    logic        wr_accept, rd_accept;
    logic        full_q, empty_q, afull_q, aempty_q;
    logic        wr_ack_q, overflow_q, data_valid_q, underflow_q;

    assign busy      = (busy_cnt_q != 2'd0);
    assign wr_accept = wr_en && !full_q  && !busy;
    assign rd_accept = rd_en && !empty_q && !busy;

    // Next pointers, occupancy and the post-reset busy down-counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        busy_cnt_d = busy_cnt_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        occ_d = wr_ptr_d - rd_ptr_d;
        if (busy) begin
            busy_cnt_d = busy_cnt_q - 2'd1;
        end
    end

    // Control state, flags and per-request status pulses.
    always_ff @(posedge fifo_clk or negedge fifo_rst) begin
        if (!fifo_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            busy_cnt_q   <= BUSY_CYCLES;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            afull_q      <= 1'b0;
            aempty_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
            overflow_q   <= 1'b0;
            data_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            busy_cnt_q   <= busy_cnt_d;
            full_q       <= (occ_d == OCC_FULL);
            empty_q      <= (occ_d == '0);
            afull_q      <= (occ_d == OCC_AFULL);
            aempty_q     <= (occ_d == OCC_AEMPTY);
            wr_ack_q     <= wr_accept;
            // Requests arriving during reset recovery are ignored, not rejected.
            overflow_q   <= wr_en && !wr_accept && !busy;
            data_valid_q <= rd_accept;
            underflow_q  <= rd_en && !rd_accept && !busy;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .RST_VALUE  (DOUT_RESET_VALUE)
    ) u_ram (
        .fifo_clk (fifo_clk),
        .fifo_rst (fifo_rst),
        .wr_en    (wr_accept),
        .wr_addr  (wr_ptr_q[AW-1:0]),
        .wr_data  (din),
        .rd_en    (rd_accept),
        .rd_addr  (rd_ptr_q[AW-1:0]),
        .rd_data  (dout)
    );

    assign full          = full_q;
    assign empty         = empty_q;
    assign almost_full   = afull_q;
    assign almost_empty  = aempty_q;
    assign wr_data_count = COUNT_WIDTH'(occ_q);
    assign rd_data_count = COUNT_WIDTH'(occ_q);
    assign wr_ack        = wr_ack_q;
    assign overflow      = overflow_q;
    assign data_valid    = data_valid_q;
    assign underflow     = underflow_q;
    assign wr_rst_busy   = busy;
    assign rd_rst_busy   = busy;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync with default parameters (32 x 16).
module tb_fifo_sync;

    logic        fifo_clk;
    logic        fifo_rst;
    logic [31:0] din;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] dout;
    logic        full, empty, almost_full, almost_empty;
    logic [4:0]  wr_data_count, rd_data_count;
    logic        wr_ack, overflow, data_valid, underflow;
    logic        wr_rst_busy, rd_rst_busy;

    int n_pass  = 0;
    int n_total = 0;

    fifo_sync dut (
        .fifo_clk      (fifo_clk),
        .fifo_rst      (fifo_rst),
        .din           (din),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .dout          (dout),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .wr_data_count (wr_data_count),
        .rd_data_count (rd_data_count),
        .wr_ack        (wr_ack),
        .overflow      (overflow),
        .data_valid    (data_valid),
        .underflow     (underflow),
        .wr_rst_busy   (wr_rst_busy),
        .rd_rst_busy   (rd_rst_busy)
    );

    initial fifo_clk = 1'b0;
    always #5 fifo_clk = ~fifo_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_count(input string tag, input int exp);
        chk({tag, "_wcnt"}, 32'(wr_data_count), 32'(exp));
        chk({tag, "_rcnt"}, 32'(rd_data_count), 32'(exp));
    endtask

    task automatic tick();
        @(posedge fifo_clk);
        #1;
    endtask

    initial begin
        din   = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        fifo_rst = 1'b1;
        #1;
        fifo_rst = 1'b0;
        #1;
        // Reset state
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_aempty", 32'(almost_empty), 32'd0);
        chk_count("rst", 0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_dvalid", 32'(data_valid), 32'd0);
        chk("rst_wbusy", 32'(wr_rst_busy), 32'd1);
        chk("rst_rbusy", 32'(rd_rst_busy), 32'd1);
        tick();
        tick();
        @(negedge fifo_clk);
        fifo_rst = 1'b1;
        tick();
        chk("busy_e1", 32'(wr_rst_busy), 32'd1);
        tick();
        chk("busy_e2", 32'(rd_rst_busy), 32'd1);
        tick();
        chk("busy_e3_w", 32'(wr_rst_busy), 32'd0);
        chk("busy_e3_r", 32'(rd_rst_busy), 32'd0);

        // Fill with 1..16
        wr_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            din = 32'(i);
            tick();
            chk("fill_ack", 32'(wr_ack), 32'd1);
            if (i == 1) chk("fill1_aempty", 32'(almost_empty), 32'd1);
            if (i == 15) begin
                chk("fill15_afull", 32'(almost_full), 32'd1);
                chk("fill15_full", 32'(full), 32'd0);
            end
        end
        chk("fill16_full", 32'(full), 32'd1);
        chk("fill16_afull", 32'(almost_full), 32'd0);
        chk("fill16_empty", 32'(empty), 32'd0);
        chk_count("fill16", 16);

        // 17th write while full
        din = 32'd17;
        tick();
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_ack", 32'(wr_ack), 32'd0);
        chk_count("ovf", 16);
        wr_en = 1'b0;
        tick();
        chk("ovf_clear", 32'(overflow), 32'd0);
        chk("dout_before_drain", dout, 32'd0);

        // Drain with rd_en held high
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("drain_dout", dout, 32'(i));
            chk("drain_dvalid", 32'(data_valid), 32'd1);
            if (i == 1) chk("drain1_afull", 32'(almost_full), 32'd1);
            if (i == 15) chk("drain15_aempty", 32'(almost_empty), 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk_count("drain", 0);
        tick();
        chk("udf_flag", 32'(underflow), 32'd1);
        chk("udf_dout", dout, 32'd16);
        chk("udf_dvalid", 32'(data_valid), 32'd0);
        rd_en = 1'b0;
        tick();
        chk("udf_clear", 32'(underflow), 32'd0);
        chk("hold_dout", dout, 32'd16);

        // Read and write together while empty: read rejected, write accepted
        wr_en = 1'b1;
        rd_en = 1'b1;
        din = 32'h55;
        tick();
        chk("emp_rw_udf", 32'(underflow), 32'd1);
        chk("emp_rw_ack", 32'(wr_ack), 32'd1);
        chk("emp_rw_dout", dout, 32'd16);
        chk_count("emp_rw", 1);
        wr_en = 1'b0;
        tick();
        chk("emp_rw_rd", dout, 32'h55);
        rd_en = 1'b0;

        // Occupancy 5, then simultaneous write/read for 4 cycles
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 32'(100 + i);
            tick();
        end
        chk_count("occ5", 5);
        rd_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din = 32'(105 + k);
            tick();
            chk_count("simul", 5);
            chk("simul_dout", dout, 32'(100 + k));
        end
        wr_en = 1'b0;
        for (int k = 4; k < 9; k++) begin
            tick();
            chk("simul_drain", dout, 32'(100 + k));
        end
        rd_en = 1'b0;
        chk("simul_empty", 32'(empty), 32'd1);

        // Wrap-around: 10 in/out, then fill completely
        wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = 32'(200 + i);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("wrap10_dout", dout, 32'(200 + i));
        end
        rd_en = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 32'(300 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("wrap_full", 32'(full), 32'd1);
        chk_count("wrap", 16);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("wrap16_dout", dout, 32'(300 + i));
        end
        rd_en = 1'b0;
        chk("wrap_empty", 32'(empty), 32'd1);

        // Reset mid-operation with occupancy 8
        wr_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            din = 32'(400 + i);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pre_rst_dout", dout, 32'd400);
        chk_count("pre_rst", 8);
        #2;
        fifo_rst = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk_count("mid_rst", 0);
        chk("mid_rst_dout", dout, 32'd0);
        chk("mid_rst_busy", 32'(wr_rst_busy), 32'd1);
        @(negedge fifo_clk);
        fifo_rst = 1'b1;
        wr_en = 1'b1;
        din = 32'hAA;
        tick();
        chk("rel_e1_busy", 32'(wr_rst_busy), 32'd1);
        chk_count("rel_e1", 0);
        tick();
        chk("rel_e2_busy", 32'(rd_rst_busy), 32'd1);
        chk_count("rel_e2", 0);
        tick();
        chk("rel_e3_busy", 32'(wr_rst_busy), 32'd0);
        chk_count("rel_e3", 0);
        chk("rel_e3_ack", 32'(wr_ack), 32'd0);
        tick();
        chk("post_busy_ack", 32'(wr_ack), 32'd1);
        chk_count("post_busy", 1);
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("post_rst_data", dout, 32'hAA);
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 16, word capacity; power of two, at least 4.
REQ-003 Parameter COUNT_WIDTH, default clog2(DEPTH)+1, width of both data-count outputs.
REQ-004 Parameter DOUT_RESET_VALUE, default 0, value of dout during and after reset.
REQ-005 fifo_clk  in  1  single clock for all logic, rising-edge.
REQ-006 fifo_rst  in  1  reset, asynchronous, active-low.
REQ-007 din  in  DATA_WIDTH  write data.
REQ-008 wr_en  in  1  write request.
REQ-009 rd_en  in  1  read request.
REQ-010 dout  out  DATA_WIDTH  read data, registered.
REQ-011 full / empty  out  1 each  occupancy == DEPTH / occupancy == 0.
REQ-012 almost_full / almost_empty  out  1 each  occupancy == DEPTH-1 / occupancy == 1.
REQ-013 wr_data_count / rd_data_count  out  COUNT_WIDTH each  current occupancy, 0..DEPTH.
REQ-014 wr_ack / overflow  out  1 each  prior-cycle write accepted / prior-cycle write rejected.
REQ-015 data_valid / underflow  out  1 each  dout updated this cycle / prior-cycle read rejected.
REQ-016 wr_rst_busy / rd_rst_busy  out  1 each  FIFO in reset recovery, requests ignored.

Function
REQ-017 Write accepted at a rising edge when wr_en=1, full=0 and wr_rst_busy=0; din stored at the write pointer; pointer increments modulo DEPTH.
REQ-018 Read accepted when rd_en=1, empty=0 and rd_rst_busy=0; the word at the read pointer appears on dout at the same edge (latency 1, standard mode, no first-word fall-through); pointer increments modulo DEPTH.
REQ-019 dout holds its last value when no read is accepted.
REQ-020 Flags and counts are registered and reflect occupancy after the edge's accepted operations.
REQ-021 Simultaneous accepted write and read: occupancy unchanged; full and empty unchanged.
REQ-022 When full, a write is rejected and a simultaneous read is accepted; occupancy becomes DEPTH-1.
REQ-023 When empty, a read is rejected and a simultaneous write is accepted; occupancy becomes 1; dout unchanged.
REQ-024 A rejected write sets overflow=1 for exactly one cycle. An accepted write sets wr_ack=1 for one cycle. Contents are preserved in both cases.
REQ-025 A rejected read sets underflow=1 for one cycle. An accepted read sets data_valid=1 in the cycle dout carries the new word. Contents are preserved in both cases.
REQ-026 Pointers carry an extra wrap bit, so full and empty are distinguished without a spare entry.

Reset
REQ-027 fifo_rst=0 asynchronously clears pointers and occupancy, and sets empty=1, full=0, almost_*=0, counts=0, wr_ack=overflow=underflow=data_valid=0, dout=DOUT_RESET_VALUE.
REQ-028 wr_rst_busy and rd_rst_busy are 1 while in reset and for 3 rising edges after fifo_rst deasserts, then 0; wr_en and rd_en are ignored while busy.
REQ-029 Reset asserted mid-operation discards all stored data immediately.

Structure
REQ-030 Shared package holds the default data width (32), default depth (16) and a data_t typedef; the count width is derived locally.
REQ-031 Storage is one sub-module, fifo_ram: a DEPTH x DATA_WIDTH simple dual-port array with a synchronous write port and a registered read port. Control, flags and counts stay in fifo_sync.

Verification
REQ-032 Release reset and wait 3 edges, then write 1..16 on consecutive cycles: full=1 after the 16th, counts=16, almost_full=1 after the 15th.
REQ-033 Write a 17th word while full: overflow=1 for one cycle, counts stay 16, and a later drain returns 1..16 unchanged.
REQ-034 Drain with rd_en held high: dout=1..16 in order, each one cycle after its read edge; empty=1 after the 16th; the next read gives underflow=1 and dout stays 16.
REQ-035 Occupancy 5, assert wr_en and rd_en together for 4 cycles: counts stay 5 and the read data is in order.
REQ-036 Wrap-around: write and read 10 words, then write 16 words: full=1 and readback is exact and in order.
REQ-037 Assert reset with occupancy 8: empty=1, counts=0 and dout=0 immediately; busy=1 for 3 edges after release; a write during busy is ignored.
